exception_controller: RTL and testbench



---
 rtl/exception_controller_pkg.sv | 21 ++
 rtl/exception_controller_priority_encoder16.sv | 17 +
 rtl/exception_controller.sv | 93 +++++++++
 tb/tb_exception_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/exception_controller_pkg.sv
// Shared types and constants for the external exception entry/exit sequencer.
package exceptionGroup;

    localparam int         NUM_SOURCES = 16;
    localparam logic [4:0] CAUSE_BASE  = 5'd16;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SAVE,
        VECTOR,
        HANDLER
    } state_t;

    typedef struct packed {
        logic       pending;
        logic       inHandler;
        logic [4:0] cause;
    } statusBus;

endpackage

// File: rtl/exception_controller_priority_encoder16.sv
// Lowest-set-bit priority encoder: bit 0 wins.
module priority_encoder16 (
    input  logic [15:0] req,
    output logic        valid,
    output logic [3:0]  index
);

    always_comb begin
        valid = |req;
        index = '0;
        // Descending scan so the lowest set bit is the last assignment.
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) index = 4'(i);
        end
    end

endmodule

// File: rtl/exception_controller.sv
// Arbitrates external exception requests, saves the return PC, vectors fetch
// into the handler table and tracks handler residency until ERET.
module exception_controller #(
    parameter int         NUM_SOURCES = exceptionGroup::NUM_SOURCES,
    parameter logic [4:0] CAUSE_BASE  = exceptionGroup::CAUSE_BASE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] exceptionReq,
    input  logic [NUM_SOURCES-1:0] exceptionMask,
    input  logic                   interruptEnable,
    input  logic [31:0]            isrBaseAddress,
    input  logic [31:0]            pcCurrent,
    input  logic                   instructionBoundary,
    input  logic                   vectorAck,
    input  logic                   returnFromException,
    output logic                   exceptionPending,
    output logic [4:0]             cause,
    output logic                   saveEn,
    output logic [31:0]            savedPc,
    output logic                   intDisable,
    output logic                   vectorValid,
    output logic [31:0]            vectorAddress,
    output logic                   inHandler
);
    import exceptionGroup::*;

    state_t                 state, stateNext;
    logic [NUM_SOURCES-1:0] enabled;
    logic                   winValid;
    logic [3:0]             winIdx;
    logic [4:0]             winCause;
    logic [4:0]             causeReg;
    logic [31:0]            pcReg, baseReg;
    statusBus               status;

    assign enabled  = interruptEnable ? (exceptionReq & exceptionMask) : '0;
    assign winCause = CAUSE_BASE + {1'b0, winIdx};

    priority_encoder16 u_penc (
        .req   (enabled),
        .valid (winValid),
        .index (winIdx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            causeReg <= '0;
            pcReg    <= '0;
            baseReg  <= '0;
        end else begin
            state <= stateNext;
            // ARM re-arbitrates each cycle so a higher-priority arrival wins.
            if ((state == IDLE || state == ARM) && winValid)
                causeReg <= winCause;
            if (state == ARM && winValid && instructionBoundary) begin
                pcReg   <= pcCurrent;
                baseReg <= isrBaseAddress;
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (winValid) stateNext = ARM;
            ARM: begin
                if (!winValid)                stateNext = IDLE;
                else if (instructionBoundary) stateNext = SAVE;
            end
            SAVE:    stateNext = VECTOR;
            VECTOR:  if (vectorAck) stateNext = HANDLER;
            HANDLER: if (returnFromException) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign status = '{pending:   (state == ARM || state == SAVE || state == VECTOR),
                      inHandler: (state == HANDLER),
                      cause:     causeReg};

    assign exceptionPending = status.pending;
    assign inHandler        = status.inHandler;
    assign cause            = status.cause;
    assign saveEn           = (state == SAVE);
    assign intDisable       = (state == SAVE);
    assign savedPc          = pcReg;
    assign vectorValid      = (state == VECTOR);
    // Base is frozen on SAVE entry, so the address holds steady until vectorAck.
    assign vectorAddress    = (state == VECTOR) ? baseReg + {25'd0, causeReg, 2'b00} : '0;

endmodule

// File: tb/tb_exception_controller.sv
// Directed and randomized checks of exception_controller against a behavioural model.
module tb_exception_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] exceptionReq = '0;
    logic [15:0] exceptionMask = '0;
    logic        interruptEnable = 1'b0;
    logic [31:0] isrBaseAddress = '0;
    logic [31:0] pcCurrent = '0;
    logic        instructionBoundary = 1'b0;
    logic        vectorAck = 1'b0;
    logic        returnFromException = 1'b0;
    logic        exceptionPending, saveEn, intDisable, vectorValid, inHandler;
    logic [4:0]  cause;
    logic [31:0] savedPc, vectorAddress;

    exception_controller dut (
        .clk                 (clk),
        .reset               (reset),
        .exceptionReq        (exceptionReq),
        .exceptionMask       (exceptionMask),
        .interruptEnable     (interruptEnable),
        .isrBaseAddress      (isrBaseAddress),
        .pcCurrent           (pcCurrent),
        .instructionBoundary (instructionBoundary),
        .vectorAck           (vectorAck),
        .returnFromException (returnFromException),
        .exceptionPending    (exceptionPending),
        .cause               (cause),
        .saveEn              (saveEn),
        .savedPc             (savedPc),
        .intDisable          (intDisable),
        .vectorValid         (vectorValid),
        .vectorAddress       (vectorAddress),
        .inHandler           (inHandler)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int saveCount = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: where the sequence currently is, as a plain phase number
    // (0 waiting, 1 arbitrating, 2 saving, 3 presenting vector, 4 in handler).
    int          ph = 0;
    logic [4:0]  mCause = '0;
    logic [31:0] mPc = '0, mBase = '0;

    function automatic int winner(input logic [15:0] r, input logic [15:0] m, input logic ie);
        if (!ie) return -1;
        for (int i = 0; i < 16; i++) if (r[i] && m[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        w = winner(exceptionReq, exceptionMask, interruptEnable);
        if (reset) begin
            ph = 0; mCause = '0; mPc = '0; mBase = '0;
        end else begin
            case (ph)
                0: if (w >= 0) begin mCause = 5'(16 + w); ph = 1; end
                1: if (w < 0) ph = 0;
                   else begin
                       mCause = 5'(16 + w);
                       if (instructionBoundary) begin
                           mPc = pcCurrent; mBase = isrBaseAddress; ph = 2;
                       end
                   end
                2: ph = 3;
                3: if (vectorAck) ph = 4;
                default: if (returnFromException) ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (saveEn) saveCount++;
            chk("pending",   32'(exceptionPending), 32'(ph >= 1 && ph <= 3));
            chk("cause",     32'(cause),            32'(mCause));
            chk("saveEn",    32'(saveEn),           32'(ph == 2));
            chk("intDis",    32'(intDisable),       32'(ph == 2));
            chk("savedPc",   savedPc,               mPc);
            chk("vecValid",  32'(vectorValid),      32'(ph == 3));
            chk("vecAddr",   vectorAddress,         (ph == 3) ? mBase + 32'(mCause) * 4 : 32'h0);
            chk("inHandler", 32'(inHandler),        32'(ph == 4));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        int sc;
        tick(2);
        started = 1;
        at_neg();
        chk("rst_pending", 32'(exceptionPending), 32'h0);
        chk("rst_cause",   32'(cause),            32'h0);
        chk("rst_vaddr",   vectorAddress,         32'h0);

        // Basic entry: source 3, boundary always available.
        tick();
        reset = 0; exceptionReq = 16'h0008; exceptionMask = 16'hFFFF; interruptEnable = 1;
        instructionBoundary = 1; isrBaseAddress = 32'h100; pcCurrent = 32'h2000;
        tick(); at_neg();
        chk("t1_arm_pending", 32'(exceptionPending), 32'h1);
        chk("t1_arm_valid",   32'(vectorValid),      32'h0);
        tick(); at_neg();
        chk("t1_saveEn", 32'(saveEn), 32'h1);
        tick(); at_neg();
        chk("t1_valid",   32'(vectorValid), 32'h1);
        chk("t1_cause",   32'(cause),       32'd19);
        chk("t1_vaddr",   vectorAddress,    32'h14C);
        chk("t1_savedPc", savedPc,          32'h2000);
        chk("t1_saves",   32'(saveCount),   32'd1);
        vectorAck = 1;
        tick(); vectorAck = 0; at_neg();
        chk("t1_inh", 32'(inHandler), 32'h1);
        chk("t1_pend_off", 32'(exceptionPending), 32'h0);
        tick(2); at_neg();
        chk("t1_ignored", 32'(inHandler), 32'h1);
        returnFromException = 1; instructionBoundary = 0;
        tick(); returnFromException = 0; at_neg();
        chk("t1_ret_idle", 32'(inHandler | exceptionPending), 32'h0);
        tick(); at_neg();
        chk("t1_reservice", 32'(exceptionPending), 32'h1);
        exceptionReq = 0;
        tick(); at_neg();
        chk("t1_drop_idle",  32'(exceptionPending), 32'h0);
        chk("t1_drop_cause", 32'(cause),            32'd19);
        chk("t1_drop_saves", 32'(saveCount),        32'd1);

        // Higher-priority arrival in ARM replaces the cause.
        exceptionReq = 16'h0020;
        tick(2); at_neg();
        chk("t2_cause5", 32'(cause), 32'd21);
        exceptionReq = 16'h0022;
        tick(); at_neg();
        chk("t2_cause1", 32'(cause), 32'd17);
        instructionBoundary = 1;
        tick(2); at_neg();
        chk("t2_vaddr", vectorAddress, 32'h144);
        vectorAck = 1;
        tick(); vectorAck = 0; exceptionReq = 0; returnFromException = 1;
        tick(); returnFromException = 0;

        // Masked source and global disable both keep the block idle.
        exceptionReq = 16'h0004; exceptionMask = 16'hFFFB;
        tick(3); at_neg();
        chk("t3_masked", 32'(exceptionPending), 32'h0);
        exceptionMask = 16'hFFFF; interruptEnable = 0;
        tick(3); at_neg();
        chk("t3_ie_off", 32'(exceptionPending), 32'h0);
        interruptEnable = 1; exceptionReq = 0;

        // Address wrap and a slow vectorAck.
        isrBaseAddress = 32'hFFFFFFF0; exceptionReq = 16'h8000;
        tick(3); at_neg();
        for (int i = 0; i < 4; i++) begin
            chk("t5_vaddr", vectorAddress,    32'h0000006C);
            chk("t5_valid", 32'(vectorValid), 32'h1);
            tick(); at_neg();
        end
        vectorAck = 1; exceptionReq = 0;
        tick(); vectorAck = 0; returnFromException = 1;
        tick(); returnFromException = 0;

        // Reset while presenting the vector abandons the sequence.
        exceptionReq = 16'h0001;
        tick(3); at_neg();
        chk("t6_in_vector", 32'(vectorValid), 32'h1);
        sc = saveCount;
        reset = 1; exceptionReq = 0;
        tick(); at_neg();
        chk("t6_rst_valid", 32'(vectorValid), 32'h0);
        reset = 0;
        tick(3); at_neg();
        chk("t6_no_save", 32'(saveCount), 32'(sc));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            exceptionReq        = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            exceptionMask       = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
            interruptEnable     = ($urandom_range(0, 7) != 0);
            instructionBoundary = ($urandom_range(0, 2) == 0);
            vectorAck           = ($urandom_range(0, 3) == 0);
            returnFromException = ($urandom_range(0, 4) == 0);
            isrBaseAddress      = $urandom;
            pcCurrent           = $urandom;
            reset               = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 0;
        at_neg();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
